// File: rtl/tri_addr_decoder.sv
// Serial tri-state-address frame decoder: address trits, data bits and a sync period.
// The DEC_LATCH_EN macro makes dado_out_parallel keep the last confirmed data after dv drops.
module tri_addr_decoder #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 4,
  parameter int BIT_CYCLES     = 32,
  parameter int SAMPLE1        = 5,
  parameter int SAMPLE2        = 20,
  parameter int SYNC_CYCLES    = 128,
  parameter int SYNC_SAMPLE    = 17,
  parameter int CONFIRM_FRAMES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_12kHz,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_01,
  input  logic [ADDR_BITS-1:0] addr_f,
  input  logic                 dado_in_serial,
  output logic [DATA_BITS-1:0] dado_out_parallel,
  output logic                 dv,
  output logic                 error_flag,
  output logic                 busy
);

  localparam int CYC_MAX = (BIT_CYCLES > SYNC_CYCLES) ? BIT_CYCLES : SYNC_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int IDX_W   = (ADDR_BITS + DATA_BITS > 1) ? $clog2(ADDR_BITS + DATA_BITS) : 1;
  localparam int MCNT_W  = $clog2(CONFIRM_FRAMES + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CYC_W-1:0]  C_S1    = CYC_W'(SAMPLE1);
  localparam logic [CYC_W-1:0]  C_S2    = CYC_W'(SAMPLE2);
  localparam logic [CYC_W-1:0]  C_BEND  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0]  C_SS    = CYC_W'(SYNC_SAMPLE);
  localparam logic [CYC_W-1:0]  C_SEND  = CYC_W'(SYNC_CYCLES - 1);
  localparam logic [IDX_W-1:0]  I_ALAST = IDX_W'(ADDR_BITS - 1);
  localparam logic [IDX_W-1:0]  I_LAST  = IDX_W'(ADDR_BITS + DATA_BITS - 1);
  localparam logic [MCNT_W-1:0] M_ONE   = MCNT_W'(1);
  localparam logic [MCNT_W-1:0] M_CONF  = MCNT_W'(CONFIRM_FRAMES);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  if (!(SAMPLE1 < SAMPLE2 && SAMPLE2 < BIT_CYCLES)) begin : g_bad_sample
    $error("tri_addr_decoder: need SAMPLE1 < SAMPLE2 < BIT_CYCLES");
  end
  if (!(SYNC_SAMPLE < SYNC_CYCLES)) begin : g_bad_sync
    $error("tri_addr_decoder: need SYNC_SAMPLE < SYNC_CYCLES");
  end
  if (CONFIRM_FRAMES < 1) begin : g_bad_confirm
    $error("tri_addr_decoder: need CONFIRM_FRAMES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SYNC} state_t;

  state_t               state;
  logic [CYC_W-1:0]     cyc;
  logic [IDX_W-1:0]     idx;
  logic [MCNT_W-1:0]    mcnt;
  logic [TO_W-1:0]      idle_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] cand;
  logic                 p1;
  logic                 p2;

  // p2 may be sampled on the evaluation cycle itself, so look through the register then.
  logic                 p2_now;
  logic                 trit_float;
  logic                 trit_illegal;
  logic                 exp_val;
  logic                 exp_float;
  logic                 trit_ok;
  logic                 same;
  logic [MCNT_W-1:0]    mcnt_next;
  logic [DATA_BITS-1:0] data_next;

  assign p2_now       = (cyc == C_S2) ? dado_in_serial : p2;
  assign trit_float   = !p1 && p2_now;
  assign trit_illegal = p1 && !p2_now;
  assign exp_val      = |(addr_01 & (ADDR_BITS'(1) << idx));
  assign exp_float    = |(addr_f & (ADDR_BITS'(1) << idx));
  assign trit_ok      = !trit_illegal && (exp_float ? trit_float : (!trit_float && (p1 == exp_val)));
  assign data_next    = (shreg << 1'b1) | DATA_BITS'(p1);
  assign same         = (shreg == cand);
  assign mcnt_next    = (mcnt == '0 || !same) ? M_ONE :
                        ((mcnt == M_CONF) ? M_CONF : mcnt + M_ONE);

  // Frame FSM, bit/sync/idle counters, confirmation logic and registered outputs.
  always_ff @(posedge clk_12kHz or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cyc               <= '0;
      idx               <= '0;
      mcnt              <= '0;
      idle_cnt          <= '0;
      shreg             <= '0;
      cand              <= '0;
      p1                <= 1'b0;
      p2                <= 1'b0;
      dado_out_parallel <= '0;
      dv                <= 1'b0;
      error_flag        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      error_flag <= 1'b0;
      if (state == ADDR || state == DATA) begin
        if (cyc == C_S1) p1 <= dado_in_serial;
        if (cyc == C_S2) p2 <= dado_in_serial;
      end
      case (state)
        IDLE: begin
          if (dado_in_serial) begin
            state    <= ADDR;
            cyc      <= '0;
            idx      <= '0;
            idle_cnt <= '0;
            busy     <= 1'b1;
          end else if (idle_cnt < TO_MAX) begin
            idle_cnt <= idle_cnt + TO_W'(1);
            if (idle_cnt == TO_LAST) begin
              dv   <= 1'b0;
              mcnt <= '0;
`ifndef DEC_LATCH_EN
              dado_out_parallel <= '0;
`endif
            end
          end else begin
            idle_cnt <= TO_MAX;
          end
        end
        ADDR: begin
          if (cyc == C_BEND) begin
            if (!trit_ok) begin
              state      <= IDLE;
              busy       <= 1'b0;
              error_flag <= 1'b1;
              mcnt       <= '0;
              dv         <= 1'b0;
`ifndef DEC_LATCH_EN
              dado_out_parallel <= '0;
`endif
            end else begin
              cyc <= '0;
              idx <= idx + IDX_W'(1);
              if (idx == I_ALAST) state <= DATA;
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        DATA: begin
          if (cyc == C_BEND) begin
            shreg <= data_next;
            cyc   <= '0;
            idx   <= idx + IDX_W'(1);
            if (idx == I_LAST) state <= SYNC;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        SYNC: begin
          if (cyc == C_SS && dado_in_serial) begin
            state      <= IDLE;
            busy       <= 1'b0;
            error_flag <= 1'b1;
            mcnt       <= '0;
            dv         <= 1'b0;
`ifndef DEC_LATCH_EN
            dado_out_parallel <= '0;
`endif
          end else if (cyc == C_SEND) begin
            state <= IDLE;
            busy  <= 1'b0;
            mcnt  <= mcnt_next;
            if (mcnt == '0 || !same) cand <= shreg;
            if (mcnt_next >= M_CONF) begin
              dado_out_parallel <= shreg;
              dv                <= 1'b1;
            end else if (!same && dv) begin
              dv <= 1'b0;
`ifndef DEC_LATCH_EN
              dado_out_parallel <= '0;
`endif
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_addr_decoder.sv
// Self-checking bench for tri_addr_decoder: directed scenarios then randomized frames,
// checked against a queue-based model of the frame acceptance and confirmation rules.
module tb_tri_addr_decoder;

  localparam int A   = 8;
  localparam int D   = 4;
  localparam int BC  = 32;
  localparam int S1  = 5;
  localparam int S2  = 20;
  localparam int SC  = 128;
  localparam int SS  = 17;
  localparam int CF  = 2;
  localparam int TO  = 1024;

  logic         clk_12kHz = 1'b0;
  logic         rst;
  logic [A-1:0] addr_01;
  logic [A-1:0] addr_f;
  logic         dado_in_serial;
  logic [D-1:0] dado_out_parallel;
  logic         dv;
  logic         error_flag;
  logic         busy;

  always #5 clk_12kHz = ~clk_12kHz;

  tri_addr_decoder #(
    .ADDR_BITS(A), .DATA_BITS(D), .BIT_CYCLES(BC), .SAMPLE1(S1), .SAMPLE2(S2),
    .SYNC_CYCLES(SC), .SYNC_SAMPLE(SS), .CONFIRM_FRAMES(CF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_12kHz(clk_12kHz), .rst(rst), .addr_01(addr_01), .addr_f(addr_f),
    .dado_in_serial(dado_in_serial), .dado_out_parallel(dado_out_parallel),
    .dv(dv), .error_flag(error_flag), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // reference model: recent accepted data since the last clear, plus published outputs
  int           q[$];
  logic         m_dv;
  logic [D-1:0] m_out;
  int           m_idle;

  // frame under construction
  logic         tp1[A];
  logic         tp2[A];
  logic [D-1:0] fdata;
  logic         fsync_bad;
  int           abort_bit = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_12kHz);
    #1;
  endtask

  task automatic model_clear();
    q.delete();
    m_dv = 1'b0;
`ifndef DEC_LATCH_EN
    m_out = '0;
`endif
  endtask

  task automatic model_accept(input logic [D-1:0] d);
    bit run_ok;
    q.push_back(int'(d));
    while (q.size() > CF) void'(q.pop_front());
    run_ok = (q.size() == CF);
    foreach (q[i]) if (q[i] != int'(d)) run_ok = 1'b0;
    if (run_ok) begin
      m_dv  = 1'b1;
      m_out = d;
    end else if (m_dv) begin
      m_dv = 1'b0;
`ifndef DEC_LATCH_EN
      m_out = '0;
`endif
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_dv"}, 32'(dv), 32'(m_dv));
    check({tag, "_dout"}, 32'(dado_out_parallel), 32'(m_out));
  endtask

  task automatic make_good();
    for (int i = 0; i < A; i++) begin
      tp1[i] = addr_f[i] ? 1'b0 : addr_01[i];
      tp2[i] = addr_f[i] ? 1'b1 : addr_01[i];
    end
    fsync_bad = 1'b0;
  endtask

  task automatic idle(input int n);
    dado_in_serial = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_idle < TO) begin
        m_idle++;
        if (m_idle == TO) model_clear();
      end
      check("idle_busy", 32'(busy), 32'd0);
      check_outs("idle");
    end
  endtask

  task automatic send_frame();
    int   err_bit;
    logic ok;
    logic flt;
    logic b1;
    logic b2;
    err_bit = -1;
    for (int i = 0; i < A; i++) begin
      if (tp1[i] && !tp2[i]) begin
        ok = 1'b0;
      end else begin
        flt = !tp1[i] && tp2[i];
        ok  = addr_f[i] ? flt : (!flt && (tp1[i] == addr_01[i]));
      end
      if (!ok && err_bit < 0) err_bit = i;
    end
    dado_in_serial = 1'b1;
    tick();
    m_idle = 0;
    check("start_busy", 32'(busy), 32'd1);
    for (int b = 0; b < A + D; b++) begin
      if (b < A) begin
        b1 = tp1[b];
        b2 = tp2[b];
      end else begin
        b1 = fdata[D-1-(b-A)];
        b2 = 1'($urandom);
      end
      for (int k = 0; k < BC; k++) begin
        dado_in_serial = (k < 13) ? b1 : b2;
        tick();
        if (b == abort_bit && k == 10) begin
          rst = 1'b1;
          #1;
          q.delete();
          m_dv = 1'b0;
          m_out = '0;
          m_idle = 0;
          dado_in_serial = 1'b0;
          check("rst_err", 32'(error_flag), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check_outs("rst");
          return;
        end
        if (k == BC - 1) begin
          if (b == err_bit) begin
            model_clear();
            check("addr_err_flag", 32'(error_flag), 32'd1);
            check("addr_err_busy", 32'(busy), 32'd0);
            check_outs("addr_err");
            dado_in_serial = 1'b0;
            return;
          end
          check("bit_err_flag", 32'(error_flag), 32'd0);
          check("bit_busy", 32'(busy), 32'd1);
          check_outs("bit");
        end
      end
    end
    for (int k = 0; k < SC; k++) begin
      dado_in_serial = (k == SS) && fsync_bad;
      tick();
      if (k == SS && fsync_bad) begin
        model_clear();
        check("sync_err_flag", 32'(error_flag), 32'd1);
        check("sync_err_busy", 32'(busy), 32'd0);
        check_outs("sync_err");
        dado_in_serial = 1'b0;
        return;
      end
      if (k == SC - 2) check_outs("presync");
      if (k == SC - 1) begin
        model_accept(fdata);
        check("acc_busy", 32'(busy), 32'd0);
        check("acc_err_flag", 32'(error_flag), 32'd0);
        check_outs("acc");
      end
    end
    dado_in_serial = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dado_in_serial = 1'b0;
    addr_01 = 8'hA5;
    addr_f = 8'h00;
    m_dv = 1'b0;
    m_out = '0;
    m_idle = 0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(error_flag), 32'd0);
    check_outs("reset");
    rst = 1'b0;
    idle(2);

    // two identical frames confirm 4'h9
    make_good();
    fdata = 4'h9;
    send_frame();
    check("t1_dv_first", 32'(dv), 32'd0);
    send_frame();
    check("t1_dv", 32'(dv), 32'd1);
    check("t1_dout", 32'(dado_out_parallel), 32'h9);

    // float trit accepted, then same trit sent as 0 rejected
    addr_f = 8'h01;
    make_good();
    send_frame();
    check("t2_dv", 32'(dv), 32'd1);
    tp1[0] = 1'b0;
    tp2[0] = 1'b0;
    send_frame();
    idle(1);

    // illegal (1,0) on trit 3, then two good frames needed again
    addr_f = 8'h00;
    make_good();
    tp1[3] = 1'b1;
    tp2[3] = 1'b0;
    send_frame();
    make_good();
    send_frame();
    check("t3_dv_first", 32'(dv), 32'd0);
    send_frame();
    check("t3_dv", 32'(dv), 32'd1);

    // data change drops dv, a repeat reconfirms
    fdata = 4'h3;
    send_frame();
    check("t4_dv_drop", 32'(dv), 32'd0);
`ifdef DEC_LATCH_EN
    check("t4_hold", 32'(dado_out_parallel), 32'h9);
`else
    check("t4_clear", 32'(dado_out_parallel), 32'h0);
`endif
    send_frame();
    check("t4_dv", 32'(dv), 32'd1);
    check("t4_dout", 32'(dado_out_parallel), 32'h3);

    // sync violation, reconfirm, then idle timeout
    fsync_bad = 1'b1;
    send_frame();
    fsync_bad = 1'b0;
    send_frame();
    send_frame();
    idle(TO - 1);
    check("t5_dv_before_to", 32'(dv), 32'd1);
    idle(1);
    check("t5_dv_to", 32'(dv), 32'd0);

    // reset in the middle of the data field, then decode from scratch
    fdata = 4'h6;
    send_frame();
    abort_bit = A + 1;
    send_frame();
    abort_bit = -1;
    #2;
    rst = 1'b0;
    idle(1);
    send_frame();
    check("t6_dv_first", 32'(dv), 32'd0);
    send_frame();
    check("t6_dv", 32'(dv), 32'd1);
    check("t6_dout", 32'(dado_out_parallel), 32'h6);

    // randomized frames
    for (int n = 0; n < 20; n++) begin
      addr_01 = A'($urandom);
      addr_f = A'($urandom);
      make_good();
      if ($urandom_range(3) == 0) begin
        int t;
        t = int'($urandom_range(A - 1));
        tp1[t] = 1'($urandom);
        tp2[t] = 1'($urandom);
      end
      if (q.size() > 0 && $urandom_range(2) != 0) fdata = D'(q[$]);
      else fdata = D'($urandom);
      fsync_bad = ($urandom_range(7) == 0);
      send_frame();
      idle(int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
